// File: rtl/uart_packet_decoder.sv
// Assembles 4-byte controller frames (SYNC, BTN_LO, BTN_HI, CHK) from a UART byte stream,
// validates the additive checksum and publishes the button word; drops stalled frames.
module uart_packet_decoder #(
  parameter logic [7:0]  c_SYNC_BYTE      = 8'hA5,
  parameter int unsigned c_TIMEOUT_CYCLES = 6510
) (
  input  logic        i_CLK,
  input  logic        i_RESET,
  input  logic [7:0]  i_RX_DATA,
  input  logic        i_RX_DATA_VALID,
  output logic [15:0] o_BUTTONS,
  output logic        o_BUTTONS_VALID,
  output logic        o_FRAME_ERR,
  output logic [7:0]  o_ERR_COUNT
);

  localparam int unsigned TmoW = $clog2(c_TIMEOUT_CYCLES);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(c_TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StGetLo, StGetHi, StGetChk} state_e;

  state_e          state_q, state_d;
  logic [7:0]      lo_q, lo_d;
  logic [7:0]      hi_q, hi_d;
  logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [15:0]     buttons_q, buttons_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;
  logic [7:0]      err_cnt_q, err_cnt_d;
  logic [7:0]      sum;

  assign sum = lo_q + hi_q;

  always_comb begin
    state_d   = state_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    tmo_cnt_d = tmo_cnt_q;
    buttons_d = buttons_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    err_cnt_d = err_cnt_q;

    if (state_q == StIdle) begin
      tmo_cnt_d = '0;
      if (i_RX_DATA_VALID && (i_RX_DATA == c_SYNC_BYTE)) begin
        state_d = StGetLo;
      end
    end else if (i_RX_DATA_VALID) begin
      // A strobe always beats a coincident timeout expiry.
      tmo_cnt_d = '0;
      case (state_q)
        StGetLo: begin
          lo_d    = i_RX_DATA;
          state_d = StGetHi;
        end
        StGetHi: begin
          hi_d    = i_RX_DATA;
          state_d = StGetChk;
        end
        default: begin
          if (i_RX_DATA == sum) begin
            buttons_d = {hi_q, lo_q};
            valid_d   = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          state_d = StIdle;
        end
      endcase
    end else if (tmo_cnt_q == TmoLast) begin
      tmo_cnt_d = '0;
      err_d     = 1'b1;
      state_d   = StIdle;
    end else begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
    end

    if (err_d && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      state_q   <= StIdle;
      lo_q      <= '0;
      hi_q      <= '0;
      tmo_cnt_q <= '0;
      buttons_q <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      lo_q      <= lo_d;
      hi_q      <= hi_d;
      tmo_cnt_q <= tmo_cnt_d;
      buttons_q <= buttons_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign o_BUTTONS       = buttons_q;
  assign o_BUTTONS_VALID = valid_q;
  assign o_FRAME_ERR     = err_q;
  assign o_ERR_COUNT     = err_cnt_q;

endmodule

// File: tb/tb_uart_packet_decoder.sv
// Bench for uart_packet_decoder: directed frames plus randomized traffic, all checked each
// cycle against a queue-based frame model.
module tb_uart_packet_decoder;

  localparam int unsigned T = 6510;

  logic        clk;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [15:0] buttons;
  logic        buttons_valid;
  logic        frame_err;
  logic [7:0]  err_count;

  int vectors = 0;
  int miscompares = 0;

  // Model state: bytes of the frame in progress, idle clocks since last strobe.
  logic [7:0]  m_q[$];
  int          m_idle = 0;
  logic [15:0] exp_buttons = '0;
  logic        exp_valid = 1'b0;
  logic        exp_err = 1'b0;
  int          exp_cnt = 0;

  uart_packet_decoder dut (
    .i_CLK           (clk),
    .i_RESET         (rst),
    .i_RX_DATA       (rx_data),
    .i_RX_DATA_VALID (rx_valid),
    .o_BUTTONS       (buttons),
    .o_BUTTONS_VALID (buttons_valid),
    .o_FRAME_ERR     (frame_err),
    .o_ERR_COUNT     (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic v, input logic [7:0] d);
    int lo, hi;
    exp_valid = 1'b0;
    exp_err   = 1'b0;
    if (r) begin
      m_q.delete();
      m_idle = 0;
      exp_buttons = '0;
      exp_cnt = 0;
      return;
    end
    if (v) begin
      m_idle = 0;
      if (m_q.size() == 0) begin
        if (d == 8'hA5) m_q.push_back(d);
      end else if (m_q.size() < 3) begin
        m_q.push_back(d);
      end else begin
        lo = int'(m_q[1]);
        hi = int'(m_q[2]);
        if (int'(d) == (lo + hi) % 256) begin
          exp_buttons = {m_q[2], m_q[1]};
          exp_valid = 1'b1;
        end else begin
          exp_err = 1'b1;
        end
        m_q.delete();
      end
    end else if (m_q.size() > 0) begin
      m_idle++;
      if (m_idle == T) begin
        m_q.delete();
        exp_err = 1'b1;
      end
    end
    if (exp_err && exp_cnt < 255) exp_cnt++;
  endtask

  // One clock: drive, let the DUT sample, advance the model, compare all outputs.
  task automatic tick(input logic r, input logic v, input logic [7:0] d);
    rst = r;
    rx_valid = v;
    rx_data = d;
    @(posedge clk);
    model_step(r, v, d);
    #1;
    check("cycle_outputs", {6'd0, buttons, buttons_valid, frame_err, err_count},
          {6'd0, exp_buttons, exp_valid, exp_err, exp_cnt[7:0]});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 8'h00);
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    tick(1'b0, 1'b1, b);
    idle(gap);
  endtask

  task automatic frame(input logic [7:0] lo, input logic [7:0] hi, input logic [7:0] chk,
                       input int gap);
    send(8'hA5, gap);
    send(lo, gap);
    send(hi, gap);
    send(chk, gap);
  endtask

  initial begin
    rst = 1'b1;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    tick(1'b1, 1'b0, 8'h00);
    tick(1'b1, 1'b0, 8'h00);
    check("reset_state", {6'd0, buttons, buttons_valid, frame_err, err_count}, 32'h0);

    // 1: slow frame, valid pulse right after the CHK strobe
    send(8'hA5, 2169);
    send(8'h34, 2169);
    send(8'h12, 2169);
    send(8'h46, 0);
    check("t1_valid", {31'd0, buttons_valid}, 32'd1);
    check("t1_buttons", {16'd0, buttons}, 32'h1234);
    idle(1);
    check("t1_single_pulse", {31'd0, buttons_valid}, 32'd0);

    // 2: checksum wraps mod 256
    frame(8'hFF, 8'h02, 8'h01, 0);
    check("t2_buttons", {16'd0, buttons}, 32'h02FF);
    check("t2_no_err", {24'd0, err_count}, 32'd0);

    // 3: bad checksum
    send(8'hA5, 0); send(8'h34, 0); send(8'h12, 0); send(8'h47, 0);
    check("t3_err", {30'd0, frame_err, buttons_valid}, 32'b10);
    check("t3_hold", {16'd0, buttons}, 32'h02FF);
    check("t3_cnt", {24'd0, err_count}, 32'd1);

    // 4: leading junk ignored
    send(8'h00, 0); send(8'h5A, 0);
    frame(8'h01, 8'h00, 8'h01, 0);
    check("t4_buttons", {16'd0, buttons}, 32'h0001);
    check("t4_cnt", {24'd0, err_count}, 32'd1);

    // 5: timeout, then strobe exactly on the expiry cycle
    tick(1'b1, 1'b0, 8'h00);
    send(8'hA5, 0);
    send(8'h10, T);
    check("t5_timeout_cnt", {24'd0, err_count}, 32'd1);
    frame(8'h20, 8'h00, 8'h20, 0);
    check("t5_buttons", {16'd0, buttons}, 32'h0020);
    send(8'hA5, 0);
    send(8'h10, T - 1);
    send(8'h00, 0);
    send(8'h10, 0);
    check("t5_edge_buttons", {16'd0, buttons}, 32'h0010);
    check("t5_edge_cnt", {24'd0, err_count}, 32'd1);

    // 6: reset mid-frame
    send(8'hA5, 0); send(8'h34, 0);
    tick(1'b1, 1'b0, 8'h00);
    check("t6_reset", {8'd0, buttons, err_count}, 32'h0);
    frame(8'h01, 8'h00, 8'h01, 0);
    check("t6_buttons", {16'd0, buttons}, 32'h0001);

    // saturation
    for (int i = 0; i < 300; i++) frame(8'h34, 8'h12, 8'h47, 0);
    check("sat_cnt", {24'd0, err_count}, 32'hFF);

    // randomized traffic
    tick(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 80; i++) begin
      logic [7:0] lo, hi, chk;
      int kind, gap;
      lo = 8'($urandom);
      hi = 8'($urandom);
      chk = lo + hi;
      kind = int'($urandom_range(0, 9));
      if (kind < 2) chk = chk ^ 8'($urandom_range(1, 255));
      if (kind == 2) send(8'($urandom), int'($urandom_range(0, 3)));
      gap = int'($urandom_range(0, 12));
      send(8'hA5, gap);
      send(lo, gap);
      if (i == 20 || i == 50) send(hi, T - 3 + int'($urandom_range(0, 5)));
      else send(hi, gap);
      send(chk, int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
